// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, stall
// vector bit positions, the NOP/bubble word and the fetched-word record.
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,   // PC stage disabled, nothing in flight
        S_REQ  = 2'd1,   // request outstanding on the instruction bus
        S_HOLD = 2'd2    // response captured, ID not accepting yet
    } fetch_state_e;

    localparam int STOP_IF = 1;
    localparam int STOP_ID = 2;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_word_t;

    // Instruction memory is word addressed; drop the byte offset.
    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave).
interface inst_fetch_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_ready;

    modport master (output inst_req, inst_addr, input inst_rdata, inst_ready);
    modport slave  (input inst_req, inst_addr, output inst_rdata, inst_ready);
endinterface

// File: rtl/inst_fetch_if_id_reg.sv
// IF/ID pipeline register: loads a fetched word, inserts bubbles, or holds
// its contents depending on the IF/ID stall bits.
module if_id_reg
    import inst_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if,
    input  logic        stall_id,
    input  logic        in_valid,
    input  fetch_word_t in_word,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid
);

    // IF stalled alone -> bubble; both stalled -> hold; otherwise load or bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_pc    <= '0;
            id_inst  <= NOP;
            id_valid <= 1'b0;
        end else if (stall_if) begin
            if (!stall_id) begin
                id_inst  <= NOP;
                id_valid <= 1'b0;
            end
        end else if (in_valid) begin
            id_pc    <= in_word.pc;
            id_inst  <= in_word.inst;
            id_valid <= 1'b1;
        end else begin
            id_inst  <= NOP;
            id_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues word fetches for the PC, buffers a response
// while ID is stalled, and feeds the IF/ID register.
// Build option: DELAY_SLOT_EN -- when defined, the instruction in flight or
// buffered at a jump is the delay slot and is delivered; otherwise it is
// squashed and reaches ID as a bubble.
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        pc,
    input  logic               ce,
    input  logic               jump_en,
    input  logic [5:0]         stop,
    inst_fetch_if.master       imem,
    output logic [31:0]        id_pc,
    output logic [31:0]        id_inst,
    output logic               id_valid,
    output logic               stallreq_if
);

    fetch_state_e state;
    fetch_word_t  buf_q;
    fetch_word_t  in_word;
    logic         buf_valid;
    logic         stop_if;
    logic         rsp;
    logic         avail;
    logic         consumed;
    logic         kill;

    assign stop_if = stop[STOP_IF];

    // A response only counts while our own request is live and ce is still up;
    // anything else is a stale reply to a dropped request.
    assign rsp      = (state == S_REQ) && imem.inst_ready && ce;
    assign avail    = rsp || ((state == S_HOLD) && buf_valid);
    assign consumed = avail && !stop_if;
    assign in_word  = rsp ? '{pc: pc, inst: imem.inst_rdata} : buf_q;

    // The PC stage is frozen by stallreq_if while a request waits, so the
    // address tracks pc directly and stays stable for the whole request.
    assign imem.inst_addr = (state == S_REQ) ? word_addr(pc) : '0;
    assign stallreq_if    = (state == S_REQ) && !imem.inst_ready;

`ifdef DELAY_SLOT_EN
    logic unused_jump;
    assign unused_jump = jump_en;
    assign kill        = 1'b0;
`else
    logic squash_q;

    // The word in flight or buffered when the jump resolves is the wrong-path
    // successor; it stays marked until it has been handed to ID as a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            squash_q <= 1'b0;
        end else if (!ce || consumed) begin
            squash_q <= 1'b0;
        end else if (jump_en && (state != S_IDLE)) begin
            squash_q <= 1'b1;
        end
    end

    // A jump in the same cycle as the response squashes that response too.
    assign kill = squash_q || jump_en;
`endif

    logic unused_stop;
    assign unused_stop = ^{stop[5:3], stop[0]};

    // Fetch FSM; inst_req is registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            imem.inst_req <= 1'b0;
        end else if (!ce) begin
            state         <= S_IDLE;
            imem.inst_req <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state         <= S_REQ;
                    imem.inst_req <= 1'b1;
                end
                S_REQ: begin
                    if (rsp && stop_if) begin
                        state         <= S_HOLD;
                        imem.inst_req <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stop_if) begin
                        state         <= S_REQ;
                        imem.inst_req <= 1'b1;
                    end
                end
                default: begin
                    state         <= S_IDLE;
                    imem.inst_req <= 1'b0;
                end
            endcase
        end
    end

    // Response buffer: captures a reply that ID cannot take this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_q     <= '0;
        end else if (!ce || consumed) begin
            buf_valid <= 1'b0;
        end else if (rsp && stop_if) begin
            buf_valid <= 1'b1;
            buf_q     <= in_word;
        end
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .stall_if (stop_if),
        .stall_id (stop[STOP_ID]),
        .in_valid (avail && !kill),
        .in_word  (in_word),
        .id_pc    (id_pc),
        .id_inst  (id_inst),
        .id_valid (id_valid)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed table-driven bench for inst_fetch. Each record gives the inputs for
// one cycle, the bus/stall outputs expected before the edge, and the IF/ID
// outputs expected after it.
module tb_inst_fetch;

`ifdef DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    localparam logic [31:0] P  = 32'h8000_0000;
    localparam logic [31:0] T  = 32'h8000_1000;
    localparam logic [31:0] T2 = 32'h8000_2000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = '0;
    logic        ce = 1'b0;
    logic        jump_en = 1'b0;
    logic [5:0]  stop = '0;
    logic [31:0] id_pc, id_inst;
    logic        id_valid, stallreq_if;

    inst_fetch_if bus ();

    inst_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .ce          (ce),
        .jump_en     (jump_en),
        .stop        (stop),
        .imem        (bus.master),
        .id_pc       (id_pc),
        .id_inst     (id_inst),
        .id_valid    (id_valid),
        .stallreq_if (stallreq_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, ce, jmp;
        logic [5:0]  stop;
        logic        rdy;
        logic [31:0] pc, rdata;
        logic        req;
        logic [31:0] addr;
        logic        stall, vld;
        logic [31:0] idpc, idinst;
    } vec_t;

    int nvec = 0;
    int nbad = 0;
    vec_t vt[27];

    function automatic vec_t mk(input logic r, c, j, input logic [5:0] s, input logic rd,
                                input logic [31:0] p, d, input logic q, input logic [31:0] a,
                                input logic st, v, input logic [31:0] ip, ii);
        vec_t x;
        x.rst = r; x.ce = c; x.jmp = j; x.stop = s; x.rdy = rd; x.pc = p; x.rdata = d;
        x.req = q; x.addr = a; x.stall = st; x.vld = v; x.idpc = ip; x.idinst = ii;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [98:0] act, input logic [98:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        logic [98:0] pre;
        int n;

        // Table (DS selects the expected jump behaviour).
        vt[0]  = mk(1,1,0,6'd0,1,P,32'hDEADBEEF,      0,0,0, 0,0,0);
        vt[1]  = mk(0,0,0,6'd0,0,P,0,                 0,0,0, 0,0,0);
        vt[2]  = mk(0,1,0,6'd0,1,P,32'hAAAA0000,      0,0,0, 0,0,0);
        vt[3]  = mk(0,1,0,6'd0,0,P,0,                 1,P,1, 0,0,0);
        vt[4]  = mk(0,1,0,6'd0,0,P,0,                 1,P,1, 0,0,0);
        vt[5]  = mk(0,1,0,6'd0,1,P,32'h3C011234,      1,P,0, 1,P,32'h3C011234);
        vt[6]  = mk(0,1,0,6'b000110,1,P+4,32'h11111111, 1,P+4,0, 1,P,32'h3C011234);
        vt[7]  = mk(0,1,0,6'b000110,0,P+4,0,          0,0,0, 1,P,32'h3C011234);
        vt[8]  = mk(0,1,0,6'b000110,0,P+4,0,          0,0,0, 1,P,32'h3C011234);
        vt[9]  = mk(0,1,0,6'd0,0,P+4,0,               0,0,0, 1,P+4,32'h11111111);
        vt[10] = mk(0,1,0,6'd0,0,P+8,0,               1,P+8,1, 0,P+4,0);
        vt[11] = mk(0,1,0,6'b000010,1,P+8,32'h22222222, 1,P+8,0, 0,P+4,0);
        vt[12] = mk(0,1,0,6'b000010,0,P+8,0,          0,0,0, 0,P+4,0);
        vt[13] = mk(0,1,0,6'd0,0,P+8,0,               0,0,0, 1,P+8,32'h22222222);
        vt[14] = mk(0,1,1,6'd0,1,P+12,32'h24020001,   1,P+12,0,
                    DS, DS ? P+12 : P+8, DS ? 32'h24020001 : 32'h0);
        vt[15] = mk(0,1,0,6'd0,0,T,0,                 1,T,1, 0, DS ? P+12 : P+8, 0);
        vt[16] = mk(0,1,0,6'd0,1,T,32'h33333333,      1,T,0, 1,T,32'h33333333);
        vt[17] = mk(0,1,0,6'b000110,1,T+4,32'h44444444, 1,T+4,0, 1,T,32'h33333333);
        vt[18] = mk(0,1,1,6'b000110,0,T+4,0,          0,0,0, 1,T,32'h33333333);
        vt[19] = mk(0,1,0,6'd0,0,T2,0,                0,0,0,
                    DS, DS ? T+4 : T, DS ? 32'h44444444 : 32'h0);
        vt[20] = mk(0,1,0,6'd0,0,T2,0,                1,T2,1, 0, DS ? T+4 : T, 0);
        vt[21] = mk(0,0,0,6'd0,0,T2,0,                1,T2,1, 0, DS ? T+4 : T, 0);
        vt[22] = mk(0,0,0,6'd0,1,T2,32'h55555555,     0,0,0, 0, DS ? T+4 : T, 0);
        vt[23] = mk(0,0,0,6'd0,0,T2,0,                0,0,0, 0, DS ? T+4 : T, 0);
        vt[24] = mk(0,1,0,6'd0,0,T2,0,                0,0,0, 0, DS ? T+4 : T, 0);
        vt[25] = mk(1,1,0,6'd0,1,T2,32'h66666666,     1,T2,0, 0,0,0);
        vt[26] = mk(0,0,0,6'd0,1,T2,32'h66666666,     0,0,0, 0,0,0);

        bus.inst_ready = 1'b1;
        bus.inst_rdata = 32'hDEADBEEF;

        // Reset with a response and ce present: everything must come up cleared.
        rst = 1'b1; ce = 1'b1; pc = P;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {bus.inst_req, bus.inst_addr, stallreq_if, id_valid, id_pc, id_inst}, '0);

        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            rst = vt[i].rst; ce = vt[i].ce; jump_en = vt[i].jmp; stop = vt[i].stop;
            pc = vt[i].pc; bus.inst_ready = vt[i].rdy; bus.inst_rdata = vt[i].rdata;
            #1;
            pre = {bus.inst_req, bus.inst_addr, stallreq_if, 65'd0};
            @(posedge clk);
            #1;
            pre[64:0] = {id_valid, id_pc, id_inst};
            chk($sformatf("vec%0d", i), pre,
                {vt[i].req, vt[i].addr, vt[i].stall, vt[i].vld, vt[i].idpc, vt[i].idinst});
        end

        // After reset release, no request may appear while ce stays low.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rst = 1'b0; ce = 1'b0; bus.inst_ready = 1'b0; jump_en = 1'b0; stop = '0;
            @(posedge clk);
            #1;
            chk("idle_no_req", {98'd0, bus.inst_req}, '0);
        end

        // ce rises: request must follow at the next edge (bounded wait).
        @(negedge clk);
        ce = 1'b1; pc = P;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.inst_req && n < 4);
        chk("req_latency", {67'd0, n}, 99'd1);

        // ce drops in the same cycle as a reply: reply dropped, request withdrawn.
        @(negedge clk);
        ce = 1'b0; bus.inst_ready = 1'b1; bus.inst_rdata = 32'h77777777;
        @(posedge clk);
        #1;
        chk("ce_drop_with_reply", {96'd0, bus.inst_req, stallreq_if, id_valid}, '0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
